// File: rtl/reg_file_mp_pkg.sv
// Shared types and elaboration helpers for the multi-port register file.
// Holds the clear-sequencer state encoding and the address-width sanity check.
package reg_file_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    // True when an ADDR_W-bit address can reach every one of num_regs registers.
    function automatic bit addr_w_fits(input int addr_w, input int num_regs);
        return (addr_w >= 1) && (addr_w <= 30) && ((1 << addr_w) >= num_regs);
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus-side bundle of the register file: one write port, two read ports, clear handshake.
// master = the datapath/control side, slave = the register file.
interface reg_file_mp_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_rej;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, clr_req,
        input  wr_rej, rd_data_a, rd_data_b, clr_busy, clr_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, clr_req,
        output wr_rej, rd_data_a, rd_data_b, clr_busy, clr_done
    );
endinterface

// File: rtl/reg_file_mp_clr_seq.sv
// Bulk-clear sequencer: walks every register index once, then pulses done.
// NUM_REGS cycles in CLEAR plus one in DONE; requests outside IDLE are dropped.
module reg_file_clr_seq
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    clr_state_t        state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            clr_we   <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        cnt      <= '0;
                        clr_busy <= 1'b1;
                        clr_we   <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == LAST) begin
                        state  <= DONE;
                        clr_we <= 1'b0;
                    end
                end
                DONE: begin
                    // busy drops in the same cycle done is seen, so a held request restarts next
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_we   <= 1'b0;
                end
            endcase
        end
    end

    assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_mp.sv
// General-purpose register file: one write port, two registered read ports, bulk clear.
// Reads land one cycle after rd_en; writes are refused (wr_rej) while a clear runs.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = 4,
    parameter bit R0_ZERO  = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input logic         clk,
    input logic         reset,
    reg_file_mp_if.slave bus
);
    if (!addr_w_fits(ADDR_W, NUM_REGS) || NUM_REGS < 2 || NUM_REGS > 256) begin : g_bad_params
        $error("reg_file_mp: NUM_REGS must be 2..256 and fit in ADDR_W bits");
    end

    localparam logic [ADDR_W:0] NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              clr_busy;
    logic              clr_done;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    // An address is live when it names a real, writable register.
    function automatic logic addr_live(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < NUM_REGS_X) && !(R0_ZERO && addr == '0);
    endfunction

    reg_file_clr_seq #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (bus.clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign bus.clr_busy = clr_busy;
    assign bus.clr_done = clr_done;

    // clr_busy covers CLEAR and DONE, i.e. every non-IDLE state
    assign wr_ok = bus.wr_en && !clr_busy && addr_live(bus.wr_addr);

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        if (addr_live(bus.rd_addr_a))
            sel_a = (BYPASS && wr_ok && bus.wr_addr == bus.rd_addr_a) ? bus.wr_data
                                                                      : regs[bus.rd_addr_a];
        if (addr_live(bus.rd_addr_b))
            sel_b = (BYPASS && wr_ok && bus.wr_addr == bus.rd_addr_b) ? bus.wr_data
                                                                      : regs[bus.rd_addr_b];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (clr_we) begin
            regs[clr_addr] <= '0;
        end else if (wr_ok) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rd_data_a <= '0;
            bus.rd_data_b <= '0;
            bus.wr_rej    <= 1'b0;
        end else begin
            if (bus.rd_en_a)
                bus.rd_data_a <= sel_a;
            if (bus.rd_en_b)
                bus.rd_data_b <= sel_b;
            bus.wr_rej <= bus.wr_en && !wr_ok;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a default instance and a 12-register, no-bypass, writable-R0 instance,
// driven in lockstep and compared every cycle against a time-window reference model.
module tb_reg_file_mp;

    logic clk;
    logic reset;

    reg_file_mp_if #(.DATA_W(32), .ADDR_W(4)) ifa ();
    reg_file_mp_if #(.DATA_W(32), .ADDR_W(4)) ifb ();

    reg_file_mp #(
        .DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .R0_ZERO(1'b1), .BYPASS(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );

    reg_file_mp #(
        .DATA_W(32), .NUM_REGS(12), .ADDR_W(4), .R0_ZERO(1'b0), .BYPASS(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    // reference model state, index 0 = dut_a, 1 = dut_b
    int          p_n   [2] = '{16, 12};
    bit          p_r0z [2] = '{1'b1, 1'b0};
    bit          p_byp [2] = '{1'b1, 1'b0};
    logic [31:0] m_mem [2][256];
    logic [31:0] m_rda [2];
    logic [31:0] m_rdb [2];
    logic        m_rej [2];
    logic        m_busy[2];
    logic        m_done[2];
    int          m_c0  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 256; k++) m_mem[d][k] = '0;
            m_rda[d] = '0; m_rdb[d] = '0;
            m_rej[d] = 1'b0; m_busy[d] = 1'b0; m_done[d] = 1'b0;
            m_c0[d] = -1000;
        end
    endtask

    function automatic logic [31:0] m_sel(input int d, input int addr, input bit acc,
                                          input int wa, input logic [31:0] wd);
        if (addr >= p_n[d] || (p_r0z[d] && addr == 0)) return '0;
        if (p_byp[d] && acc && wa == addr) return wd;
        return m_mem[d][addr];
    endfunction

    // A clear sampled at edge c0 owns edges c0+1 .. c0+n+1; edge c0+1+k zeroes register k.
    task automatic m_edge(input int d, input logic we, input int wa, input logic [31:0] wd,
                          input logic rea, input int raa, input logic reb, input int rab,
                          input logic cr);
        bit idle, acc;
        int k;
        idle = !(edge_no >= m_c0[d] + 1 && edge_no <= m_c0[d] + p_n[d] + 1);
        acc  = we && idle && wa < p_n[d] && !(p_r0z[d] && wa == 0);
        if (rea) m_rda[d] = m_sel(d, raa, acc, wa, wd);
        if (reb) m_rdb[d] = m_sel(d, rab, acc, wa, wd);
        m_rej[d] = we && !acc;
        if (acc) m_mem[d][wa] = wd;
        if (!idle) begin
            k = edge_no - m_c0[d] - 1;
            if (k < p_n[d]) m_mem[d][k] = '0;
        end
        if (idle && cr) m_c0[d] = edge_no;
        m_busy[d] = edge_no >= m_c0[d] && edge_no <= m_c0[d] + p_n[d];
        m_done[d] = edge_no == m_c0[d] + p_n[d] + 1;
    endtask

    task automatic cmp_model();
        chk("A.rd_data_a", ifa.rd_data_a, m_rda[0]);
        chk("A.rd_data_b", ifa.rd_data_b, m_rdb[0]);
        chk("A.wr_rej",    32'(ifa.wr_rej),   32'(m_rej[0]));
        chk("A.clr_busy",  32'(ifa.clr_busy), 32'(m_busy[0]));
        chk("A.clr_done",  32'(ifa.clr_done), 32'(m_done[0]));
        chk("B.rd_data_a", ifb.rd_data_a, m_rda[1]);
        chk("B.rd_data_b", ifb.rd_data_b, m_rdb[1]);
        chk("B.wr_rej",    32'(ifb.wr_rej),   32'(m_rej[1]));
        chk("B.clr_busy",  32'(ifb.clr_busy), 32'(m_busy[1]));
        chk("B.clr_done",  32'(ifb.clr_done), 32'(m_done[1]));
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic rea, input logic [3:0] raa, input logic reb,
                         input logic [3:0] rab, input logic cr);
        ifa.wr_en = we;  ifa.wr_addr = wa;    ifa.wr_data = wd;
        ifa.rd_en_a = rea; ifa.rd_addr_a = raa; ifa.rd_en_b = reb; ifa.rd_addr_b = rab;
        ifa.clr_req = cr;
        ifb.wr_en = we;  ifb.wr_addr = wa;    ifb.wr_data = wd;
        ifb.rd_en_a = rea; ifb.rd_addr_a = raa; ifb.rd_en_b = reb; ifb.rd_addr_b = rab;
        ifb.clr_req = cr;
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, compare 1 ns later.
    task automatic step(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic rea, input logic [3:0] raa, input logic reb,
                        input logic [3:0] rab, input logic cr);
        @(negedge clk);
        drive(we, wa, wd, rea, raa, reb, rab, cr);
        @(posedge clk);
        edge_no++;
        for (int d = 0; d < 2; d++)
            m_edge(d, we, int'(wa), wd, rea, int'(raa), reb, int'(rab), cr);
        #1;
        cmp_model();
    endtask

    task automatic step_idle();
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".A.rd_data_a"}, ifa.rd_data_a, 32'd0);
        chk({tag, ".A.rd_data_b"}, ifa.rd_data_b, 32'd0);
        chk({tag, ".A.wr_rej"},    32'(ifa.wr_rej), 32'd0);
        chk({tag, ".A.clr_busy"},  32'(ifa.clr_busy), 32'd0);
        chk({tag, ".A.clr_done"},  32'(ifa.clr_done), 32'd0);
        chk({tag, ".B.rd_data_a"}, ifb.rd_data_a, 32'd0);
        chk({tag, ".B.rd_data_b"}, ifb.rd_data_b, 32'd0);
        chk({tag, ".B.clr_busy"},  32'(ifb.clr_busy), 32'd0);
    endtask

    // Pulse clr_req once, try a write to reg 2 mid-clear, and measure busy length / done position.
    task automatic run_clear(input string tag);
        int busy_a = 0, busy_b = 0, done_a = -1, done_b = -1;
        for (int j = 0; j <= 30; j++) begin
            step(1'(j == 8), 4'd2, 32'hBAD0_0002, 1'b0, 4'd0, 1'b0, 4'd0, 1'(j == 0));
            if (ifa.clr_busy) busy_a++;
            if (ifb.clr_busy) busy_b++;
            if (ifa.clr_done && done_a < 0) done_a = j;
            if (ifb.clr_done && done_b < 0) done_b = j;
            if (j == 8) begin
                chk({tag, ".A.mid_wr_rej"}, 32'(ifa.wr_rej), 32'd1);
                chk({tag, ".B.mid_wr_rej"}, 32'(ifb.wr_rej), 32'd1);
            end
        end
        chk({tag, ".A.busy_cycles"}, busy_a, 32'd17);
        chk({tag, ".A.done_at"},     done_a, 32'd17);
        chk({tag, ".B.busy_cycles"}, busy_b, 32'd13);
        chk({tag, ".B.done_at"},     done_b, 32'd13);
    endtask

    typedef struct {
        logic        we;  logic [3:0] wa;  logic [31:0] wd;
        logic        rea; logic [3:0] raa; logic reb; logic [3:0] rab;
        logic [31:0] a_rda; logic [31:0] a_rdb; logic a_rej;
        logic [31:0] b_rda; logic [31:0] b_rdb; logic b_rej;
    } vec_t;

    vec_t vt [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b1, 4'd3,  32'hDEAD_BEEF, 1'b0, 4'd0,  1'b0, 4'd0,
                   32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
        vt[1]  = '{1'b0, 4'd0,  32'h0,         1'b1, 4'd3,  1'b0, 4'd0,
                   32'hDEAD_BEEF, 32'h0, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vt[2]  = '{1'b1, 4'd5,  32'h1,         1'b0, 4'd0,  1'b0, 4'd0,
                   32'hDEAD_BEEF, 32'h0, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vt[3]  = '{1'b1, 4'd5,  32'h1234_5678, 1'b0, 4'd0,  1'b1, 4'd5,
                   32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF, 32'h1, 1'b0};
        vt[4]  = '{1'b0, 4'd0,  32'h0,         1'b1, 4'd5,  1'b1, 4'd5,
                   32'h1234_5678, 32'h1234_5678, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0};
        vt[5]  = '{1'b1, 4'd0,  32'hFFFF_FFFF, 1'b1, 4'd0,  1'b0, 4'd0,
                   32'h0, 32'h1234_5678, 1'b1, 32'h0, 32'h1234_5678, 1'b0};
        vt[6]  = '{1'b0, 4'd0,  32'h0,         1'b1, 4'd0,  1'b1, 4'd0,
                   32'h0, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vt[7]  = '{1'b1, 4'd15, 32'hAAAA_5555, 1'b0, 4'd0,  1'b1, 4'd15,
                   32'h0, 32'hAAAA_5555, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1};
        vt[8]  = '{1'b0, 4'd0,  32'h0,         1'b1, 4'd15, 1'b1, 4'd15,
                   32'hAAAA_5555, 32'hAAAA_5555, 1'b0, 32'h0, 32'h0, 1'b0};
        vt[9]  = '{1'b1, 4'd3,  32'h1111_1111, 1'b0, 4'd3,  1'b0, 4'd3,
                   32'hAAAA_5555, 32'hAAAA_5555, 1'b0, 32'h0, 32'h0, 1'b0};
        vt[10] = '{1'b1, 4'd15, 32'h2222_2222, 1'b0, 4'd15, 1'b0, 4'd0,
                   32'hAAAA_5555, 32'hAAAA_5555, 1'b0, 32'h0, 32'h0, 1'b1};
        vt[11] = '{1'b0, 4'd0,  32'h0,         1'b1, 4'd3,  1'b1, 4'd11,
                   32'h1111_1111, 32'h0, 1'b0, 32'h1111_1111, 32'h0, 1'b0};

        m_reset();
        reset = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // directed vectors: write/read, bypass vs no bypass, R0, out-of-range, read hold
        for (int i = 0; i < 12; i++) begin
            step(vt[i].we, vt[i].wa, vt[i].wd, vt[i].rea, vt[i].raa, vt[i].reb, vt[i].rab, 1'b0);
            chk($sformatf("vec%0d.A.rd_data_a", i), ifa.rd_data_a, vt[i].a_rda);
            chk($sformatf("vec%0d.A.rd_data_b", i), ifa.rd_data_b, vt[i].a_rdb);
            chk($sformatf("vec%0d.A.wr_rej", i),    32'(ifa.wr_rej), 32'(vt[i].a_rej));
            chk($sformatf("vec%0d.B.rd_data_a", i), ifb.rd_data_a, vt[i].b_rda);
            chk($sformatf("vec%0d.B.rd_data_b", i), ifb.rd_data_b, vt[i].b_rdb);
            chk($sformatf("vec%0d.B.wr_rej", i),    32'(ifb.wr_rej), 32'(vt[i].b_rej));
        end

        // fill, clear, then confirm every register reads back zero
        for (int i = 0; i < 16; i++)
            step(1'b1, 4'(i), 32'h0000_0100 + 32'(i), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        run_clear("clr1");
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'd0, 32'd0, 1'b1, 4'(i), 1'b1, 4'(i), 1'b0);
            chk($sformatf("swp%0d.A.rd_data_a", i), ifa.rd_data_a, 32'd0);
            chk($sformatf("swp%0d.B.rd_data_b", i), ifb.rd_data_b, 32'd0);
        end

        // held request restarts right after the done cycle
        for (int j = 0; j < 20; j++) begin
            step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
            if (j == 17) begin
                chk("held.A.done_at17", 32'(ifa.clr_done), 32'd1);
                chk("held.A.busy_at17", 32'(ifa.clr_busy), 32'd0);
            end
            if (j == 18) chk("held.A.restart", 32'(ifa.clr_busy), 32'd1);
        end
        repeat (20) step_idle();

        // reset in the middle of a clear
        step(1'b1, 4'd4, 32'h0000_0044, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 1'b1, 4'd4, 1'b0);
        chk("pre_rst.A.rd_data_a", ifa.rd_data_a, 32'h0000_0044);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        repeat (5) step_idle();
        chk("mid_clr.A.busy", 32'(ifa.clr_busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        m_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_clear("clr2");

        // random traffic with occasional clears
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 49) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
